// File: rtl/mux_stream_rr_pkg.sv
`default_nettype none
// ============================================================================
// mux_stream_pkg : shared mode encoding and counter width for mux_stream_rr
// Rev 1.0 - initial release
// ============================================================================
package mux_stream_pkg;

  typedef enum logic {
    MUX_MODE_SEL = 1'b0,
    MUX_MODE_RR  = 1'b1
  } mux_mode_e;

  localparam int MUX_COUNT_W = 32;

endpackage
`default_nettype wire

// File: rtl/mux_stream_rr_if.sv
`default_nettype none
// ============================================================================
// mux_stream_rr_if : N-channel input streams, select controls and output stream
// Rev 1.0 - initial release
// ============================================================================
interface mux_stream_rr_if
  import mux_stream_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data_i;
  logic [CHANNELS-1:0]       in_valid_i;
  logic [CHANNELS-1:0]       in_ready_o;
  mux_mode_e                 mode_i;
  logic [SEL_W-1:0]          select_i;
  logic [WIDTH-1:0]          out_data_o;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [SEL_W-1:0]          grant_o;

  // Slave is the multiplexer; master drives producers and the consumer.
  modport slave (
    input  in_data_i, in_valid_i, mode_i, select_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, grant_o
  );

  modport master (
    output in_data_i, in_valid_i, mode_i, select_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, grant_o
  );

endinterface
`default_nettype wire

// File: rtl/mux_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, first request at or above ptr
// Rev 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_W-1:0]    ptr_i,
  output logic [CHANNELS-1:0] gnt_o,
  output logic [SEL_W-1:0]    idx_o,
  output logic                any_o
);

  localparam logic [SEL_W:0]      C_CH  = (SEL_W+1)'(CHANNELS);
  localparam logic [CHANNELS-1:0] C_ONE = CHANNELS'(1);

  logic [SEL_W:0] pos;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    // Extra bit on pos keeps ptr+i from overflowing before the wrap.
    for (int i = 0; i < CHANNELS; i++) begin
      pos = {1'b0, ptr_i} + (SEL_W+1)'(i);
      if (pos >= C_CH) pos = pos - C_CH;
      if (!any_o && (pos < C_CH) && req_i[pos[SEL_W-1:0]]) begin
        any_o = 1'b1;
        idx_o = pos[SEL_W-1:0];
      end
    end
    gnt_o = any_o ? (C_ONE << idx_o) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/mux_stream_rr.sv
`default_nettype none
// ============================================================================
// mux_stream_rr : N-channel stream mux, explicit select or round-robin, with
// one registered output stage. Optional MUX_STREAM_COUNT_EN adds xfer_count_o.
// Rev 1.0 - initial release
// ============================================================================
module mux_stream_rr
  import mux_stream_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  mux_stream_rr_if.slave bus
`ifdef MUX_STREAM_COUNT_EN
  ,
  output logic [MUX_COUNT_W-1:0] xfer_count_o
`endif
);

  localparam logic [SEL_W:0]      C_CH   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0]    C_LAST = SEL_W'(CHANNELS-1);
  localparam logic [CHANNELS-1:0] C_ONE  = CHANNELS'(1);

  logic [WIDTH-1:0]    ch_data [CHANNELS];
  logic [CHANNELS-1:0] rr_gnt;
  logic [SEL_W-1:0]    rr_idx;
  logic                rr_any;
  logic                sel_req;
  logic                cand;
  logic                load_en;
  logic [SEL_W-1:0]    chosen;
  logic [CHANNELS-1:0] ready_vec;

  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    data_q,  data_d;
  logic [SEL_W-1:0]    grant_q, grant_d;
  logic [SEL_W-1:0]    ptr_q,   ptr_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign ch_data[g] = bus.in_data_i[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req_i (bus.in_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  always_comb begin
    sel_req = ({1'b0, bus.select_i} < C_CH) && bus.in_valid_i[bus.select_i];
    load_en = !valid_q || bus.out_ready_i;

    if (bus.mode_i == MUX_MODE_RR) begin
      chosen    = rr_idx;
      cand      = rr_any;
      ready_vec = rr_gnt;
    end else begin
      chosen    = bus.select_i;
      cand      = sel_req;
      ready_vec = sel_req ? (C_ONE << bus.select_i) : '0;
    end

    valid_d = valid_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (cand) begin
        valid_d = 1'b1;
        data_d  = ch_data[chosen];
        grant_d = chosen;
        if (bus.mode_i == MUX_MODE_RR) begin
          ptr_d = (chosen == C_LAST) ? '0 : chosen + SEL_W'(1);
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready_o  = load_en ? ready_vec : '0;
  assign bus.out_data_o  = data_q;
  assign bus.out_valid_o = valid_q;
  assign bus.grant_o     = grant_q;

`ifdef MUX_STREAM_COUNT_EN
  logic [MUX_COUNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (valid_q && bus.out_ready_i && (xfer_cnt_q != {MUX_COUNT_W{1'b1}})) begin
      xfer_cnt_d = xfer_cnt_q + MUX_COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) xfer_cnt_q <= '0;
    else          xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_count_o = xfer_cnt_q;
`endif

endmodule
`default_nettype wire
